// File: rtl/instr_assembler.sv
// rtl/instr_assembler.sv - RV32I immediate packer with IMEM address stamping; checks enabled by ASM_RANGE_CHECK_EN
module instr_assembler #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        immsrc,
  input  logic [31:0]       imm,
  input  logic [31:0]       base,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_load_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [2:0]        err_code,
  input  logic              err_clr
);

  logic [31:0]       packed_word;
  logic [2:0]        chk_code;
  logic              take;
  logic              good;
  logic [ADDR_W-1:0] cnt;

  // The output register can refill whenever it is empty or being drained this cycle
  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready;
  assign good     = take && (chk_code == 3'b000);

  // Overlay the immediate onto the template's format-specific fields
  always_comb begin
    packed_word = base;
    case (immsrc)
      3'b000: packed_word[31:20] = imm[11:0];
      3'b001: begin
        packed_word[31:25] = imm[11:5];
        packed_word[11:7]  = imm[4:0];
      end
      3'b010: begin
        packed_word[31]    = imm[12];
        packed_word[30:25] = imm[10:5];
        packed_word[11:8]  = imm[4:1];
        packed_word[7]     = imm[11];
      end
      3'b011: begin
        packed_word[31]    = imm[20];
        packed_word[30:21] = imm[10:1];
        packed_word[20]    = imm[11];
        packed_word[19:12] = imm[19:12];
      end
      3'b100: packed_word[31:12] = imm[31:12];
      default: packed_word = base;
    endcase
  end

`ifdef ASM_RANGE_CHECK_EN
  // Classify the offered immediate; the highest-priority fault is reported
  always_comb begin
    chk_code = 3'b000;
    if (immsrc > 3'b100) begin
      chk_code = 3'b100;
    end else if ((immsrc == 3'b010 || immsrc == 3'b011) && imm[0]) begin
      chk_code = 3'b010;
    end else if (immsrc == 3'b100 && imm[11:0] != 12'd0) begin
      chk_code = 3'b011;
    end else begin
      case (immsrc)
        3'b000, 3'b001: if (!(&imm[31:11] || ~|imm[31:11])) chk_code = 3'b001;
        3'b010:         if (!(&imm[31:12] || ~|imm[31:12])) chk_code = 3'b001;
        3'b011:         if (!(&imm[31:20] || ~|imm[31:20])) chk_code = 3'b001;
        default:        chk_code = 3'b000;
      endcase
    end
  end

  // Sticky error: first code is kept until cleared; a new error beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      err      <= 1'b0;
      err_code <= 3'b000;
    end else if (take && chk_code != 3'b000) begin
      err <= 1'b1;
      if (!err || err_clr) err_code <= chk_code;
    end else if (err_clr) begin
      err      <= 1'b0;
      err_code <= 3'b000;
    end
  end
`else
  logic unused_err_clr;

  assign chk_code       = 3'b000;
  assign err            = 1'b0;
  assign err_code       = 3'b000;
  assign unused_err_clr = err_clr;
`endif

  // Output register: load a good word when there is room, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_addr  <= '0;
    end else if (in_ready) begin
      out_valid <= good;
      if (good) begin
        out_data <= packed_word;
        out_addr <= addr_load ? addr_load_val : cnt;
      end
    end
  end

  // IMEM address counter; a load overrides the increment and the accepted word uses the loaded value
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (addr_load) begin
      cnt <= addr_load_val + ADDR_W'(good);
    end else if (good) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// tb/tb_instr_assembler.sv - directed and randomized checks of instr_assembler against a transaction model
module tb_instr_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  immsrc;
  logic [31:0] imm;
  logic [31:0] base;
  logic        addr_load;
  logic [7:0]  addr_load_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_addr;
  logic        err;
  logic [2:0]  err_code;
  logic        err_clr;

  int checks   = 0;
  int failures = 0;

  logic        m_valid;
  logic [31:0] m_data;
  logic [7:0]  m_addr;
  logic [7:0]  m_cnt;
  logic        m_err;
  logic [2:0]  m_code;

  instr_assembler #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .immsrc(immsrc), .imm(imm), .base(base),
    .addr_load(addr_load), .addr_load_val(addr_load_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .err(err), .err_code(err_code), .err_clr(err_clr)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_pack(input logic [2:0] s, input logic [31:0] i, input logic [31:0] b);
    case (s)
      3'd0: return (b & 32'h000FFFFF) | (i << 20);
      3'd1: return (b & 32'h01FFF07F) | (((i >> 5) & 32'h7F) << 25) | ((i & 32'h1F) << 7);
      3'd2: return (b & 32'h01FFF07F) | (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25)
                   | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7);
      3'd3: return (b & 32'h00000FFF) | (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21)
                   | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12);
      3'd4: return (b & 32'h00000FFF) | (i & 32'hFFFFF000);
      default: return b;
    endcase
  endfunction

  function automatic logic [2:0] ref_code(input logic [2:0] s, input logic [31:0] i);
    int v;
    logic [2:0] c;
    v = $signed(i);
    c = 3'd0;
    if (s > 3'd4) c = 3'd4;
    else if ((s == 3'd2 || s == 3'd3) && (i % 2) != 0) c = 3'd2;
    else if (s == 3'd4 && (i % 4096) != 0) c = 3'd3;
    else if (s <= 3'd1 && (v < -2048 || v > 2047)) c = 3'd1;
    else if (s == 3'd2 && (v < -4096 || v > 4095)) c = 3'd1;
    else if (s == 3'd3 && (v < -1048576 || v > 1048575)) c = 3'd1;
`ifndef ASM_RANGE_CHECK_EN
    c = 3'd0;
`endif
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and update the transaction model from the inputs seen at that edge
  task automatic tick();
    logic       acc;
    logic [2:0] c;
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0; m_data = 32'd0; m_addr = 8'd0; m_cnt = 8'd0; m_err = 1'b0; m_code = 3'd0;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      c   = ref_code(immsrc, imm);
      if (m_valid && out_ready) m_valid = 1'b0;
      if (acc && c == 3'd0) begin
        m_valid = 1'b1;
        m_data  = ref_pack(immsrc, imm, base);
        m_addr  = addr_load ? addr_load_val : m_cnt;
        m_cnt   = m_addr + 8'd1;
      end else if (addr_load) begin
        m_cnt = addr_load_val;
      end
      if (acc && c != 3'd0) begin
        if (!m_err || err_clr) m_code = c;
        m_err = 1'b1;
      end else if (err_clr) begin
        m_err = 1'b0; m_code = 3'd0;
      end
    end
    #1;
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, !m_valid || out_ready);
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_addr", out_addr, m_addr);
    chk("err", err, m_err);
    chk("err_code", err_code, m_code);
  endtask

  task automatic cyc(input logic rst, input logic v, input logic [2:0] s, input logic [31:0] i,
                     input logic [31:0] b, input logic ordy, input logic ld, input logic [7:0] ldv,
                     input logic clr);
    @(negedge clk);
    reset = rst; in_valid = v; immsrc = s; imm = i; base = b;
    out_ready = ordy; addr_load = ld; addr_load_val = ldv; err_clr = clr;
    tick();
    check_all();
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] r;
    logic [31:0] ri;
    logic [2:0]  rs;

    // Reset state
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_in_ready", in_ready, 1);

    // I-type, lowest legal immediate
    cyc(0, 1, 3'd0, 32'hFFFFF800, 32'h00000013, 1, 0, 0, 0);
    chk("i_data", out_data, 32'h80000013);
    chk("i_addr", out_addr, 8'h00);

    // B then U after a fresh reset
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 3'd2, 32'h00000FFE, 32'h00000063, 1, 0, 0, 0);
    chk("b_data", out_data, 32'h7E000FE3);
    cyc(0, 1, 3'd4, 32'h12345000, 32'h00000537, 1, 0, 0, 0);
    chk("u_data", out_data, 32'h12345537);
    chk("u_addr", out_addr, 8'h01);

    // Error capture, first-error retention and clear
    cyc(0, 1, 3'd3, 32'h00000003, 32'h0000006F, 1, 0, 0, 0);
`ifdef ASM_RANGE_CHECK_EN
    chk("j_mis_valid", out_valid, 0);
    chk("j_mis_code", err_code, 3'b010);
`else
    chk("j_mis_emitted", out_valid, 1);
`endif
    cyc(0, 1, 3'd0, 32'h00000800, 32'h00000013, 1, 0, 0, 0);
`ifdef ASM_RANGE_CHECK_EN
    chk("range_code_kept", err_code, 3'b010);
`endif
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1);
    chk("err_cleared", err, 0);
    cyc(0, 1, 3'd0, 32'h00000001, 32'h00000013, 1, 0, 0, 0);

    // Backpressure with one word in the register and one held at the input
    cyc(0, 1, 3'd0, 32'h00000005, 32'h00000013, 1, 0, 0, 0);
    held = out_data;
    chk("bp_first", held, 32'h00500013);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 3'd0, 32'hFFFFFFFF, 32'h00000093, 0, 0, 0, 0);
      chk("bp_stall_ready", in_ready, 0);
      chk("bp_stall_stable", out_data, held);
    end
    cyc(0, 1, 3'd0, 32'hFFFFFFFF, 32'h00000093, 1, 0, 0, 0);
    chk("bp_second", out_data, 32'hFFF00093);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("bp_drained", out_valid, 0);

    // Address load together with a good word, then wrap
    cyc(0, 1, 3'd0, 32'h00000007, 32'h00000013, 1, 1, 8'hFE, 0);
    chk("ld_addr_fe", out_addr, 8'hFE);
    cyc(0, 1, 3'd0, 32'h00000008, 32'h00000013, 1, 0, 0, 0);
    chk("ld_addr_ff", out_addr, 8'hFF);
    cyc(0, 1, 3'd0, 32'h00000009, 32'h00000013, 1, 0, 0, 0);
    chk("ld_addr_wrap", out_addr, 8'h00);

    // Reset while the output is stalled
    cyc(0, 1, 3'd4, 32'hABCDE000, 32'h00000037, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_rst_valid", out_valid, 0);
    cyc(0, 1, 3'd1, 32'h00000123, 32'h00002023, 1, 0, 0, 0);
    chk("stall_rst_addr", out_addr, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      r  = $urandom;
      rs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      case ($urandom_range(0, 4))
        0: ri = r;
        1: ri = {{20{r[11]}}, r[11:0]};
        2: ri = {{19{r[12]}}, r[12:1], 1'b0};
        3: ri = {{11{r[20]}}, r[20:1], 1'b0};
        default: ri = {r[31:12], 12'd0};
      endcase
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, rs, ri, $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 8'($urandom),
          $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_assembler.md
# instr_assembler

Streaming RV32I instruction assembler. It takes an immediate value, an immediate-format selector and a template instruction word, and packs the immediate into the format-specific bit positions; this is the inverse of the datapath immediate extender. Packed words are emitted with a sequential instruction-memory word address for the boot/test loader that fills IMEM. One register stage with valid/ready flow control and a sticky encoding-error report.

## Interface
- ADDR_W, 8: IMEM word-address width; address counter width.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input word offered.
- in_ready  out  1  input accepted when in_valid && in_ready.
- immsrc  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U; 101–111 illegal.
- imm  in  32  immediate value, two's complement.
- base  in  32  template word (opcode/rd/rs/funct); immediate bit positions are overwritten.
- addr_load  in  1  load the address counter.
- addr_load_val  in  ADDR_W  new counter value.
- out_valid  out  1  packed word available.
- out_ready  in  1  consumer takes the word when out_valid && out_ready.
- out_data  out  32  packed instruction.
- out_addr  out  ADDR_W  IMEM word address for out_data.
- err  out  1  sticky error flag.
- err_code  out  3  first error: 001 range, 010 misaligned, 011 U low bits nonzero, 100 illegal immsrc.
- err_clr  in  1  clears err and err_code.

## Operation
- Packing. Bits not listed keep their value from base.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - U: [31:12]=imm[31:12].
- Checks (priority order: illegal > misaligned > U-low > range):
  - I/S: imm[31:11] all equal, i.e. range -2048..2047.
  - B: imm[0]=0; imm[31:12] all equal.
  - J: imm[0]=0; imm[31:20] all equal.
  - U: imm[11:0]=0.
- Errored input:
  - Consumed (in_ready handshake completes) but not emitted.
  - Counter unchanged; err set.
  - err_code is written only while err=0, so the first error is kept.
- Good input: captured into the output register with address = counter; counter increments by 1, wrapping 2^ADDR_W−1 → 0.
- addr_load takes priority over an increment in the same cycle. A good word accepted in that cycle gets addr_load_val, and the counter becomes addr_load_val+1.
- err_clr in the same cycle as a new error: the new error wins (err=1, code written).
- Output register:
  - in_ready = !out_valid || out_ready.
  - out_data and out_addr are held stable while out_valid && !out_ready.

## Timing
- Latency 1 cycle: input accepted at edge N → out_valid=1 with data after edge N.
- Full throughput: 1 word/cycle while out_ready=1.
- in_ready is combinational from out_valid/out_ready; there is no combinational path from in_* to out_*.
- Reset, including mid-stall:
  - Outputs: out_valid=0, out_data=0, out_addr=0, err=0, err_code=000.
  - Counter=0.
  - in_ready=1 in the first cycle after reset.
  - Any pending word is discarded.

## Configuration
- ASM_RANGE_CHECK_EN defined: all checks above active.
- ASM_RANGE_CHECK_EN undefined:
  - No checks; imm is truncated silently into the listed bits.
  - Illegal immsrc emits base unchanged.
  - Every accepted input is emitted and increments the counter.
  - err and err_code are tied to 0.

## Test plan
- I-type: imm=0xFFFFF800, base=0x00000013, after reset → out_data=0x80000013, out_addr=0x00, err=0.
- B-type: imm=0x00000FFE, base=0x00000063 → out_data=0x7E000FE3; U-type: imm=0x12345000, base=0x00000537 → out_data=0x12345537, out_addr=0x01.
- Errors: J imm=0x00000003 → no out_valid, err=1, err_code=010, counter unchanged. Then I imm=0x00000800 → err_code stays 010. Then err_clr → err=0. Repeat without ASM_RANGE_CHECK_EN → the word is emitted.
- Backpressure: out_ready=0 for 3 cycles with in_valid held and two words queued. Required: in_ready=0 during the stall and out_data stable; on release, both words emerge in order on consecutive cycles.
- Wrap and load: addr_load_val=0xFE with ADDR_W=8, asserted together with a good input; then two more inputs → out_addr 0xFE, 0xFF, 0x00.
- Mid-stall reset: assert reset while out_valid=1 and out_ready=0 → out_valid=0 and counter=0 the next cycle; the next word gets out_addr=0x00.
